// File: rtl/definitions_pkg.sv
// Shared types for the arithmetic/display path: fixed-width signed operands
// plus the restoring divider's state encoding and iteration counter type.
package definitions_pkg;

  typedef logic signed [7:0]  int8_t;
  typedef logic signed [15:0] int16_t;

  localparam int DIV_ITER = 16;

  typedef logic [$clog2(DIV_ITER)-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DIVIDE,
    DONE
  } div_state_e;

endpackage

// File: rtl/div_iter_cntr.sv
// Iteration counter for the restoring divider: synchronous clear and enable,
// with a terminal-count flag raised while the count sits on its last value.
module div_iter_cntr
  import definitions_pkg::*;
#(
  parameter int LAST = DIV_ITER - 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output cnt_t cnt,
  output logic tc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == cnt_t'(LAST));

endmodule

// File: rtl/restoring_divider.sv
// Signed 16/8 restoring divider: operands are reduced to magnitudes, divided one
// bit per cycle, then sign-corrected so the quotient truncates toward zero.
module restoring_divider
  import definitions_pkg::*;
#(
  parameter int DIV_ITER = definitions_pkg::DIV_ITER
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  int16_t     i_dividend,
  input  int8_t      i_divisor,
  output int16_t     o_quotient,
  output int8_t      o_remainder,
  output logic       o_rdy,
  output logic       o_busy,
  output logic       o_dvz,
  output logic       o_ovf,
  output cnt_t       o_cnt,
  output div_state_e o_Edo_Act
);

  div_state_e  state;
  int16_t      dividend_q;
  int8_t       divisor_q;
  logic [15:0] dq;
  logic [7:0]  dvs_mag;
  logic [7:0]  prem;
  logic        q_neg;
  logic        r_neg;
  logic        dvz_pend;
  logic        cnt_tc;
  logic        cnt_clr;
  logic        cnt_en;

  // The shifted partial remainder never exceeds 255 and the divisor magnitude
  // 128, so a 9-bit difference is wide enough for its MSB to be the borrow.
  logic [8:0] prem_sh;
  logic [8:0] trial;
  logic       borrow;

  assign prem_sh = {prem, dq[15]};
  assign trial   = prem_sh - {1'b0, dvs_mag};
  assign borrow  = trial[8];

  assign cnt_clr   = (state == LOAD);
  assign cnt_en    = (state == DIVIDE);
  assign o_Edo_Act = state;

  div_iter_cntr #(
    .LAST(DIV_ITER - 1)
  ) u_cntr (
    .clk(clk),
    .rst(rst),
    .en (cnt_en),
    .clr(cnt_clr),
    .cnt(o_cnt),
    .tc (cnt_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      dividend_q  <= '0;
      divisor_q   <= '0;
      dq          <= '0;
      dvs_mag     <= '0;
      prem        <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dvz_pend    <= 1'b0;
      o_quotient  <= '0;
      o_remainder <= '0;
      o_rdy       <= 1'b0;
      o_busy      <= 1'b0;
      o_dvz       <= 1'b0;
      o_ovf       <= 1'b0;
    end else begin
      o_rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            dividend_q <= i_dividend;
            divisor_q  <= i_divisor;
            o_dvz      <= 1'b0;
            o_ovf      <= 1'b0;
            dvz_pend   <= (i_divisor == '0);
            if (i_divisor == '0) begin
              state <= DONE;
            end else begin
              state  <= LOAD;
              o_busy <= 1'b1;
            end
          end
        end

        LOAD: begin
          dq      <= dividend_q[15] ? (~dividend_q + 16'd1) : dividend_q;
          dvs_mag <= divisor_q[7] ? (~divisor_q + 8'd1) : divisor_q;
          q_neg   <= dividend_q[15] ^ divisor_q[7];
          r_neg   <= dividend_q[15];
          prem    <= '0;
          state   <= DIVIDE;
        end

        // The dividend register doubles as the quotient: each shift frees its
        // LSB, which receives the new quotient bit.
        DIVIDE: begin
          dq   <= {dq[14:0], ~borrow};
          prem <= borrow ? prem_sh[7:0] : trial[7:0];
          if (cnt_tc) begin
            state  <= DONE;
            o_busy <= 1'b0;
          end
        end

        DONE: begin
          o_rdy <= 1'b1;
          state <= IDLE;
          if (dvz_pend) begin
            o_quotient  <= '0;
            o_remainder <= '0;
            o_dvz       <= 1'b1;
          end else begin
            o_quotient  <= q_neg ? (~dq + 16'd1) : dq;
            o_remainder <= r_neg ? (~prem + 8'd1) : prem;
            o_ovf       <= !q_neg && (dq == 16'h8000);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: a scoreboard of natively computed
// quotients/remainders is compared against each o_rdy pulse.
`timescale 1ns/1ps
module tb_restoring_divider;
  import definitions_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_start;
  int16_t     i_dividend;
  int8_t      i_divisor;
  int16_t     o_quotient;
  int8_t      o_remainder;
  logic       o_rdy;
  logic       o_busy;
  logic       o_dvz;
  logic       o_ovf;
  cnt_t       o_cnt;
  div_state_e o_Edo_Act;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dvz;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  restoring_divider #(
    .DIV_ITER(DIV_ITER)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .o_quotient (o_quotient),
    .o_remainder(o_remainder),
    .o_rdy      (o_rdy),
    .o_busy     (o_busy),
    .o_dvz      (o_dvz),
    .o_ovf      (o_ovf),
    .o_cnt      (o_cnt),
    .o_Edo_Act  (o_Edo_Act)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Native SV division already truncates toward zero with the remainder
  // taking the dividend's sign.
  function automatic exp_t model(input int dvd, input int dvs);
    exp_t e;
    int   q;
    int   r;
    e.q   = '0;
    e.r   = '0;
    e.dvz = 1'b1;
    e.ovf = 1'b0;
    e.lat = 1;
    if (dvs != 0) begin
      q     = dvd / dvs;
      r     = dvd % dvs;
      e.q   = q[15:0];
      e.r   = r[7:0];
      e.dvz = 1'b0;
      e.ovf = (q == 32768);
      e.lat = DIV_ITER + 2;
    end
    return e;
  endfunction

  task automatic applyStimulus(input int16_t dvd, input int8_t dvs, input bit disturb);
    exp_t e;
    int   cyc;
    @(negedge clk);
    i_dividend = dvd;
    i_divisor  = dvs;
    i_start    = 1'b1;
    sb.push_back(model(dvd, dvs));
    @(posedge clk);
    #1;
    i_start = 1'b0;
    checkOutput("dvz_clear", {31'b0, o_dvz}, 32'd0);
    checkOutput("ovf_clear", {31'b0, o_ovf}, 32'd0);
    checkOutput("busy_accept", {31'b0, o_busy}, {31'b0, (dvs != 0)});
    cyc = 0;
    while (!o_rdy && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (disturb && cyc >= 1 && cyc <= 15) begin
        i_start    = 1'($urandom_range(0, 1));
        i_dividend = int16_t'($urandom);
        i_divisor  = int8_t'($urandom);
      end else begin
        i_start = 1'b0;
      end
    end
    i_start = 1'b0;
    e = sb.pop_front();
    if (!o_rdy) begin
      checkOutput("rdy_timeout", {31'b0, o_rdy}, 32'd1);
      return;
    end
    checkOutput("latency", cyc, e.lat);
    checkOutput("quotient", {16'b0, o_quotient}, {16'b0, e.q});
    checkOutput("remainder", {24'b0, o_remainder}, {24'b0, e.r});
    checkOutput("dvz", {31'b0, o_dvz}, {31'b0, e.dvz});
    checkOutput("ovf", {31'b0, o_ovf}, {31'b0, e.ovf});
    @(posedge clk);
    #1;
    checkOutput("rdy_pulse", {31'b0, o_rdy}, 32'd0);
    checkOutput("idle_after", {30'b0, o_Edo_Act}, {30'b0, IDLE});
    checkOutput("hold_q", {16'b0, o_quotient}, {16'b0, e.q});
    checkOutput("hold_r", {24'b0, o_remainder}, {24'b0, e.r});
  endtask

  task automatic applyAbort(input int16_t dvd, input int8_t dvs);
    bit saw_rdy;
    @(negedge clk);
    i_dividend = dvd;
    i_divisor  = dvs;
    i_start    = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("abort_q", {16'b0, o_quotient}, 32'd0);
    checkOutput("abort_r", {24'b0, o_remainder}, 32'd0);
    checkOutput("abort_state", {30'b0, o_Edo_Act}, {30'b0, IDLE});
    checkOutput("abort_cnt", {28'b0, o_cnt}, 32'd0);
    checkOutput("abort_busy", {31'b0, o_busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    saw_rdy = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (o_rdy) saw_rdy = 1'b1;
    end
    checkOutput("abort_no_rdy", {31'b0, saw_rdy}, 32'd0);
  endtask

  initial begin
    rst        = 1'b0;
    i_start    = 1'b0;
    i_dividend = '0;
    i_divisor  = '0;
    #12;
    checkOutput("rst_state", {30'b0, o_Edo_Act}, {30'b0, IDLE});
    checkOutput("rst_q", {16'b0, o_quotient}, 32'd0);
    checkOutput("rst_r", {24'b0, o_remainder}, 32'd0);
    checkOutput("rst_rdy", {31'b0, o_rdy}, 32'd0);
    checkOutput("rst_busy", {31'b0, o_busy}, 32'd0);
    checkOutput("rst_dvz", {31'b0, o_dvz}, 32'd0);
    checkOutput("rst_ovf", {31'b0, o_ovf}, 32'd0);
    checkOutput("rst_cnt", {28'b0, o_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    applyStimulus(100, 7, 1'b0);
    applyStimulus(-100, 7, 1'b0);
    applyStimulus(100, -7, 1'b0);
    applyStimulus(-100, -7, 1'b0);
    applyStimulus(-32768, -1, 1'b0);
    applyStimulus(-32768, 1, 1'b0);
    applyStimulus(1234, 0, 1'b0);
    applyStimulus(1234, 10, 1'b0);
    applyStimulus(500, 9, 1'b1);
    applyAbort(50, 3);
    applyStimulus(50, 3, 1'b0);
    applyStimulus(1000, -128, 1'b0);
    applyStimulus(32767, 127, 1'b0);
    applyStimulus(5, 9, 1'b0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(int16_t'($urandom), (i == 3) ? 8'sd0 : int8_t'($urandom), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
